// File: rtl/traffic_phase_ctrl.sv
// rtl/traffic_phase_ctrl.sv - phase sequencer driving the traffic-light down-counter
// Optional FLASH_MODE_EN adds a flash input and a blinking FLASH phase.
module traffic_phase_ctrl #(
  parameter int pCNT_WIDTH    = 5,
  parameter int pINIT_WIDTH   = 3,
  parameter int pSIDE_YEL_CNT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic                   cnt_last,
  input  logic [pCNT_WIDTH-1:0]  cnt_count,
`ifdef FLASH_MODE_EN
  input  logic                   flash,
`endif
  output logic                   cnt_en,
  output logic [pINIT_WIDTH-1:0] cnt_init,
  output logic [2:0]             light_main,
  output logic [2:0]             light_side,
  output logic [1:0]             phase
);

  localparam logic [1:0] ST_GREEN  = 2'd0;
  localparam logic [1:0] ST_YELLOW = 2'd1;
  localparam logic [1:0] ST_RED    = 2'd2;
  localparam logic [1:0] ST_FLASH  = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [pINIT_WIDTH-1:0] cnt_init_q, cnt_init_d;
  logic                   load;
`ifdef FLASH_MODE_EN
  logic                   blink_q, blink_d;
`endif

  // The counter still shows the previous phase's zero during a load cycle,
  // so cnt_last must not be trusted until the init has landed.
  assign load = |cnt_init_q;

  always_comb begin
    state_d    = state_q;
    cnt_init_d = '0;
    if (!load && tick && cnt_last) begin
      case (state_q)
        ST_GREEN:  state_d = ST_YELLOW;
        ST_YELLOW: state_d = ST_RED;
        default:   state_d = ST_GREEN;
      endcase
      cnt_init_d = pINIT_WIDTH'(1) << state_d;
    end
`ifdef FLASH_MODE_EN
    blink_d = blink_q;
    if (state_q == ST_FLASH) begin
      if (tick) blink_d = ~blink_q;
      if (flash) begin
        state_d    = ST_FLASH;
        cnt_init_d = '0;
      end else begin
        state_d    = ST_GREEN;
        cnt_init_d = pINIT_WIDTH'(1);
      end
    end else if (flash) begin
      state_d    = ST_FLASH;
      cnt_init_d = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_GREEN;
      cnt_init_q <= pINIT_WIDTH'(1);
`ifdef FLASH_MODE_EN
      blink_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_init_q <= cnt_init_d;
`ifdef FLASH_MODE_EN
      blink_q    <= blink_d;
`endif
    end
  end

  always_comb begin
    cnt_en     = tick | load;
    light_main = 3'b001;
    light_side = 3'b100;
    case (state_q)
      ST_YELLOW: light_main = 3'b010;
      ST_RED: begin
        light_main = 3'b100;
        // all-red clearance for the load cycle, then side follows the count
        if (!load)
          light_side = (cnt_count > pCNT_WIDTH'(pSIDE_YEL_CNT)) ? 3'b001 : 3'b010;
      end
      default: ;
    endcase
`ifdef FLASH_MODE_EN
    if (state_q == ST_FLASH) begin
      cnt_en     = 1'b0;
      light_main = blink_q ? 3'b010 : 3'b000;
      light_side = blink_q ? 3'b100 : 3'b000;
    end
`endif
  end

  assign cnt_init = cnt_init_q;
  assign phase    = state_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb/tb_traffic_phase_ctrl.sv - self-checking bench for traffic_phase_ctrl
// Vector table, timed phase sequences with a counter model, and randomized reference-model checks.
module tb_traffic_phase_ctrl;

  logic       clk = 1'b0;
  logic       rst, tick, cnt_last;
  logic [4:0] cnt_count;
`ifdef FLASH_MODE_EN
  logic       flash;
  localparam bit HAS_FLASH = 1'b1;
`else
  localparam bit HAS_FLASH = 1'b0;
`endif
  logic       cnt_en;
  logic [2:0] cnt_init, light_main, light_side;
  logic [1:0] phase;

  traffic_phase_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick), .cnt_last(cnt_last), .cnt_count(cnt_count),
`ifdef FLASH_MODE_EN
    .flash(flash),
`endif
    .cnt_en(cnt_en), .cnt_init(cnt_init), .light_main(light_main),
    .light_side(light_side), .phase(phase)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst, tick, last;
    logic [4:0] cnt;
    logic [2:0] main, side, init;
    logic       en;
    logic [1:0] ph;
  } vec_t;
  vec_t vecs[16];

  // environment counter (14/2/17) and abstract reference model
  int  ctr = 0;
  bit  free_mode = 1'b0;
  int  m_ph = 0;
  bit  m_load = 1'b0;
  bit  m_blink = 1'b0;

  logic [2:0] main_log[$], side_log[$], init_log[$];
  logic [1:0] ph_log[$];
  logic       en_log[$], tick_log[$];
  logic [4:0] cnt_log[$];

  task automatic clear_logs();
    main_log.delete(); side_log.delete(); init_log.delete();
    ph_log.delete(); en_log.delete(); tick_log.delete(); cnt_log.delete();
  endtask

  task automatic cycle(input logic r, input logic t, input logic fl);
    logic [2:0] e_main, e_side, e_init;
    logic       e_en;
    int         ctr_n;
    rst  = r;
    tick = t;
`ifdef FLASH_MODE_EN
    flash = fl;
`endif
    if (free_mode) begin
      cnt_count = 5'($urandom);
      cnt_last  = 1'($urandom_range(0, 1));
    end else begin
      cnt_count = 5'(ctr);
      cnt_last  = (ctr == 0);
    end
    #1;
    if (m_ph == 3) begin
      e_main = m_blink ? 3'b010 : 3'b000;
      e_side = m_blink ? 3'b100 : 3'b000;
      e_init = 3'b000;
      e_en   = 1'b0;
    end else begin
      e_main = 3'(1 << m_ph);
      e_side = (m_ph == 2 && !m_load) ? ((cnt_count > 5'd2) ? 3'b001 : 3'b010) : 3'b100;
      e_init = m_load ? 3'(1 << m_ph) : 3'b000;
      e_en   = t | m_load;
    end
    check("light_main", 32'(light_main), 32'(e_main));
    check("light_side", 32'(light_side), 32'(e_side));
    check("cnt_init", 32'(cnt_init), 32'(e_init));
    check("cnt_en", 32'(cnt_en), 32'(e_en));
    check("phase", 32'(phase), 32'(m_ph));
    main_log.push_back(light_main); side_log.push_back(light_side);
    init_log.push_back(cnt_init);   ph_log.push_back(phase);
    en_log.push_back(cnt_en);       tick_log.push_back(t);
    cnt_log.push_back(cnt_count);
    ctr_n = ctr;
    if (cnt_en === 1'b1) begin
      if (cnt_init[0])      ctr_n = 14;
      else if (cnt_init[1]) ctr_n = 2;
      else if (cnt_init[2]) ctr_n = 17;
      else if (ctr > 0)     ctr_n = ctr - 1;
    end
    if (r) begin
      m_ph = 0; m_load = 1'b1; m_blink = 1'b0;
    end else if (m_ph == 3) begin
      if (t) m_blink = !m_blink;
      if (!fl) begin m_ph = 0; m_load = 1'b1; end
    end else if (fl && HAS_FLASH) begin
      m_ph = 3; m_load = 1'b0;
    end else if (m_load) begin
      m_load = 1'b0;
    end else if (t && cnt_last) begin
      m_ph = (m_ph + 1) % 3; m_load = 1'b1;
    end
    @(posedge clk); #1;
    ctr = ctr_n;
  endtask

  initial begin
    int errs, pulses, run, ticks, c, j, o;
    int e_ph, e_side, e_init;
    bit done, fl_state;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 5'd0,  3'b001, 3'b100, 3'b001, 1'b1, 2'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 5'd0,  3'b001, 3'b100, 3'b001, 1'b1, 2'd0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 5'd5,  3'b001, 3'b100, 3'b000, 1'b1, 2'd0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 5'd0,  3'b001, 3'b100, 3'b000, 1'b0, 2'd0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 5'd0,  3'b001, 3'b100, 3'b000, 1'b1, 2'd0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 5'd0,  3'b010, 3'b100, 3'b010, 1'b1, 2'd1};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 5'd0,  3'b010, 3'b100, 3'b000, 1'b0, 2'd1};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 5'd0,  3'b010, 3'b100, 3'b000, 1'b1, 2'd1};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 5'd0,  3'b100, 3'b100, 3'b100, 1'b1, 2'd2};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 5'd17, 3'b100, 3'b001, 3'b000, 1'b1, 2'd2};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 5'd3,  3'b100, 3'b001, 3'b000, 1'b0, 2'd2};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 5'd2,  3'b100, 3'b010, 3'b000, 1'b0, 2'd2};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 5'd31, 3'b100, 3'b001, 3'b000, 1'b1, 2'd2};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 5'd0,  3'b100, 3'b010, 3'b000, 1'b1, 2'd2};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 5'd0,  3'b001, 3'b100, 3'b001, 1'b1, 2'd0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 5'd0,  3'b001, 3'b100, 3'b000, 1'b0, 2'd0};

    rst = 1'b1; tick = 1'b0; cnt_last = 1'b0; cnt_count = '0;
`ifdef FLASH_MODE_EN
    flash = 1'b0;
`endif
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      rst = vecs[i].rst; tick = vecs[i].tick;
      cnt_last = vecs[i].last; cnt_count = vecs[i].cnt;
      #1;
      check($sformatf("vec%0d_main", i), 32'(light_main), 32'(vecs[i].main));
      check($sformatf("vec%0d_side", i), 32'(light_side), 32'(vecs[i].side));
      check($sformatf("vec%0d_init", i), 32'(cnt_init), 32'(vecs[i].init));
      check($sformatf("vec%0d_en", i), 32'(cnt_en), 32'(vecs[i].en));
      check($sformatf("vec%0d_phase", i), 32'(phase), 32'(vecs[i].ph));
      @(posedge clk); #1;
    end

    // two full periods with tick held high
    cycle(1'b1, 1'b1, 1'b0); cycle(1'b1, 1'b1, 1'b0);
    clear_logs();
    repeat (78) cycle(1'b0, 1'b1, 1'b0);
    errs = 0; pulses = 0;
    for (int i = 0; i < 78; i++) begin
      o = i % 39;
      e_ph   = (o < 16) ? 0 : (o < 20) ? 1 : 2;
      e_side = (o == 20) ? 4 : (o > 20 && o <= 35) ? 1 : (o > 35) ? 2 : 4;
      e_init = (o == 0) ? 1 : (o == 16) ? 2 : (o == 20) ? 4 : 0;
      if (32'(ph_log[i]) != e_ph) errs++;
      if (32'(side_log[i]) != e_side) errs++;
      if (32'(init_log[i]) != e_init) errs++;
      if (init_log[i] != 3'b000) begin
        pulses++;
        if (!$onehot(init_log[i]) || en_log[i] !== 1'b1) errs++;
      end
    end
    check("period_sequence_errs", 32'(errs), 32'd0);
    check("period_init_pulses", 32'(pulses), 32'd6);

    // tick withheld for 10 cycles while YELLOW sits at zero
    cycle(1'b1, 1'b1, 1'b0);
    clear_logs();
    repeat (19) cycle(1'b0, 1'b1, 1'b0);
    repeat (10) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    errs = 0;
    for (int i = 19; i < 29; i++)
      if (ph_log[i] != 2'd1 || init_log[i] != 3'b000 || cnt_log[i] != 5'd0) errs++;
    check("yellow_hold_errs", 32'(errs), 32'd0);
    check("yellow_release_init", 32'(init_log[30]), 32'd4);
    check("yellow_release_phase", 32'(ph_log[30]), 32'd2);

    // reset pulse mid-RED at count 9
    cycle(1'b1, 1'b1, 1'b0);
    clear_logs();
    repeat (29) cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    check("midred_count_at_rst", 32'(cnt_log[29]), 32'd9);
    check("midred_phase_at_rst", 32'(ph_log[29]), 32'd2);
    clear_logs();
    repeat (20) cycle(1'b0, 1'b1, 1'b0);
    check("midred_main_after", 32'(main_log[0]), 32'd1);
    check("midred_init_after", 32'(init_log[0]), 32'd1);
    check("midred_en_after", 32'(en_log[0]), 32'd1);
    run = 0;
    while (run < 20 && ph_log[run] == 2'd0) run++;
    check("midred_green_len", 32'(run), 32'd16);

`ifdef FLASH_MODE_EN
    cycle(1'b1, 1'b1, 1'b0);
    clear_logs();
    repeat (3) cycle(1'b0, 1'b1, 1'b0);
    c = 0;
    for (int k = 0; k < 16; k++) begin
      cycle(1'b0, (c % 4) == 0, 1'b1);
      c++;
    end
    errs = 0;
    for (int i = 4; i < 19; i++) begin
      if (en_log[i] !== 1'b0 || init_log[i] != 3'b000 || ph_log[i] != 2'd3) errs++;
      if (32'(main_log[i]) != ((((i - 4) / 4) % 2) ? 32'd2 : 32'd0)) errs++;
    end
    check("flash_blink_errs", 32'(errs), 32'd0);
    cycle(1'b0, (c % 4) == 0, 1'b0);
    c++;
    ticks = 0; done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      cycle(1'b0, (c % 4) == 0, 1'b0);
      c++;
      j = ph_log.size() - 1;
      if (k == 0) check("flash_exit_init", 32'(init_log[j]), 32'd1);
      if (ph_log[j] == 2'd1) done = 1'b1;
      else if (ph_log[j] == 2'd0 && init_log[j] == 3'b000 && tick_log[j]) ticks++;
    end
    check("flash_exit_done", 32'(done), 32'd1);
    check("flash_exit_green_ticks", 32'(ticks), 32'd15);
`endif

    // randomized traffic with free-running counter inputs
    free_mode = 1'b1;
    fl_state = 1'b0;
    cycle(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 19) == 0) fl_state = !fl_state;
      cycle($urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0, fl_state & HAS_FLASH);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
